// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: synchronises interrupt lines, picks the committing
// exception/interrupt/ERET, pulses cp0's exception inputs and drives the pipeline flush.
module exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  int_ext_i,
  input  logic        timer_int_i,
  input  logic        valid_i,
  input  logic        stall_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        adel_if_i,
  input  logic        ri_i,
  input  logic        syscall_i,
  input  logic        break_i,
  input  logic        trap_i,
  input  logic        ov_i,
  input  logic        adel_i,
  input  logic        ades_i,
  input  logic        eret_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        wb_cp0_we_i,
  input  logic [4:0]  wb_cp0_waddr_i,
  input  logic [31:0] wb_cp0_data_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic [5:0]  int_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o
);

  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_INT  = 32'h0000_0001;
  localparam logic [31:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [31:0] EXC_ADES = 32'h0000_0005;
  localparam logic [31:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [31:0] EXC_BP   = 32'h0000_0009;
  localparam logic [31:0] EXC_RI   = 32'h0000_000a;
  localparam logic [31:0] EXC_OV   = 32'h0000_000c;
  localparam logic [31:0] EXC_TR   = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  localparam logic [1:0] CNT_INIT = 2'(FLUSH_CYCLES - 1);
  localparam logic       GO_FLUSH = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic [5:0]  sync1_q;
  logic [5:0]  sync2_q;
  logic [31:0] excepttype_q;
  logic [31:0] cur_addr_q;
  logic        ds_q;
  logic [31:0] bad_addr_q;
  logic        flush_q;
  logic [31:0] new_pc_q;

  logic [5:0]  int_s;
  logic [31:0] eff_status_s;
  logic [1:0]  eff_cause_ip_s;
  logic [31:0] eff_epc_s;
  logic        int_pending_s;
  logic [31:0] code_s;
  logic        addr_err_s;
  logic [31:0] bad_val_s;
  logic        commit_s;
  logic        unused_s;

  // Two-flop synchroniser for the asynchronous interrupt lines
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 6'd0;
      sync2_q <= 6'd0;
    end else begin
      sync1_q <= int_ext_i;
      sync2_q <= sync1_q;
    end
  end

  // Timer interrupt already lives in clk domain, so it bypasses the synchroniser
  assign int_s = {sync2_q[5] | timer_int_i, sync2_q[4:0]};

  // Forward an mtc0 sitting in WB so the decision sees the newest cp0 state
  always_comb begin
    eff_status_s   = cp0_status_i;
    eff_cause_ip_s = cp0_cause_i[9:8];
    eff_epc_s      = cp0_epc_i;
    if (wb_cp0_we_i && (wb_cp0_waddr_i == REG_STATUS)) begin
      eff_status_s = wb_cp0_data_i;
    end else begin
      eff_status_s = cp0_status_i;
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == REG_CAUSE)) begin
      eff_cause_ip_s = wb_cp0_data_i[9:8];
    end else begin
      eff_cause_ip_s = cp0_cause_i[9:8];
    end
    if (wb_cp0_we_i && (wb_cp0_waddr_i == REG_EPC)) begin
      eff_epc_s = wb_cp0_data_i;
    end else begin
      eff_epc_s = cp0_epc_i;
    end
  end

  assign int_pending_s = ((|(int_s & eff_status_s[15:10])) ||
                          (|(eff_cause_ip_s & eff_status_s[9:8]))) &&
                         eff_status_s[0] && !eff_status_s[1];

  // Fixed-priority cause selection; only address errors carry a bad address
  always_comb begin
    code_s     = EXC_NONE;
    addr_err_s = 1'b0;
    bad_val_s  = 32'h0000_0000;
    if (int_pending_s) begin
      code_s = EXC_INT;
    end else if (adel_if_i) begin
      code_s     = EXC_ADEL;
      addr_err_s = 1'b1;
      bad_val_s  = pc_i;
    end else if (ri_i) begin
      code_s = EXC_RI;
    end else if (syscall_i) begin
      code_s = EXC_SYS;
    end else if (break_i) begin
      code_s = EXC_BP;
    end else if (trap_i) begin
      code_s = EXC_TR;
    end else if (ov_i) begin
      code_s = EXC_OV;
    end else if (adel_i) begin
      code_s     = EXC_ADEL;
      addr_err_s = 1'b1;
      bad_val_s  = mem_addr_i;
    end else if (ades_i) begin
      code_s     = EXC_ADES;
      addr_err_s = 1'b1;
      bad_val_s  = mem_addr_i;
    end else if (eret_i) begin
      code_s = EXC_ERET;
    end else begin
      code_s = EXC_NONE;
    end
  end

  // The !flush_q term keeps pulses apart when the flush window is a single cycle
  assign commit_s = (state_q == ST_IDLE) && !flush_q && valid_i && !stall_i &&
                    (code_s != EXC_NONE);

  // Commit FSM with registered cp0 pulse, flush and redirect outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      excepttype_q <= 32'h0000_0000;
      cur_addr_q   <= 32'h0000_0000;
      ds_q         <= 1'b0;
      bad_addr_q   <= 32'h0000_0000;
      flush_q      <= 1'b0;
      new_pc_q     <= 32'h0000_0000;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (commit_s) begin
            excepttype_q <= code_s;
            cur_addr_q   <= pc_i;
            ds_q         <= is_in_delayslot_i;
            bad_addr_q   <= addr_err_s ? bad_val_s : bad_addr_q;
            flush_q      <= 1'b1;
            new_pc_q     <= (code_s == EXC_ERET) ? eff_epc_s : HANDLER_ADDR;
            cnt_q        <= CNT_INIT;
            state_q      <= GO_FLUSH ? ST_FLUSH : ST_IDLE;
          end else begin
            excepttype_q <= EXC_NONE;
            cur_addr_q   <= 32'h0000_0000;
            ds_q         <= 1'b0;
            flush_q      <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        ST_FLUSH: begin
          excepttype_q <= EXC_NONE;
          cur_addr_q   <= 32'h0000_0000;
          ds_q         <= 1'b0;
          if (cnt_q == 2'd0) begin
            flush_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            flush_q <= 1'b1;
            cnt_q   <= cnt_q - 2'd1;
          end
        end
        default: begin
          excepttype_q <= EXC_NONE;
          flush_q      <= 1'b0;
          cnt_q        <= 2'd0;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign excepttype_o        = excepttype_q;
  assign current_inst_addr_o = cur_addr_q;
  assign is_in_delayslot_o   = ds_q;
  assign bad_addr_o          = bad_addr_q;
  assign int_o               = int_s;
  assign flush_o             = flush_q;
  assign new_pc_o            = new_pc_q;

  assign unused_s = ^{cp0_cause_i[31:10], cp0_cause_i[7:0],
                      eff_status_s[31:16], eff_status_s[7:2]};

endmodule

// File: tb/tb_exc_ctrl.sv
// Scoreboard bench for exc_ctrl: expected pulses are queued at stimulus time and
// checked by a monitor on the falling edge whenever excepttype_o pulses.
module tb_exc_ctrl;

  localparam logic [31:0] HANDLER = 32'hBFC0_0380;
  localparam int          FLUSH_N = 2;

  logic        clk;
  logic        rst;
  logic [5:0]  int_ext_i;
  logic        timer_int_i, valid_i, stall_i, is_in_delayslot_i;
  logic [31:0] pc_i, mem_addr_i, cp0_status_i, cp0_cause_i, cp0_epc_i, wb_cp0_data_i;
  logic        adel_if_i, ri_i, syscall_i, break_i, trap_i, ov_i, adel_i, ades_i, eret_i;
  logic        wb_cp0_we_i;
  logic [4:0]  wb_cp0_waddr_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o;
  logic [5:0]  int_o;

  typedef struct {
    logic [31:0] code;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [31:0] npc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_bad = 32'h0;
  logic [31:0] last_npc = 32'h0;
  logic [31:0] prev_exc = 32'h0;
  int          flush_len = 0;

  exc_ctrl dut (
    .clk(clk), .rst(rst), .int_ext_i(int_ext_i), .timer_int_i(timer_int_i),
    .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i),
    .adel_if_i(adel_if_i), .ri_i(ri_i), .syscall_i(syscall_i), .break_i(break_i),
    .trap_i(trap_i), .ov_i(ov_i), .adel_i(adel_i), .ades_i(ades_i), .eret_i(eret_i),
    .mem_addr_i(mem_addr_i), .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .wb_cp0_we_i(wb_cp0_we_i), .wb_cp0_waddr_i(wb_cp0_waddr_i),
    .wb_cp0_data_i(wb_cp0_data_i), .excepttype_o(excepttype_o),
    .current_inst_addr_o(current_inst_addr_o), .is_in_delayslot_o(is_in_delayslot_o),
    .bad_addr_o(bad_addr_o), .int_o(int_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] code, input logic [31:0] pc, input logic ds,
                          input logic [31:0] bad, input logic [31:0] npc);
    exp_t e;
    e.code = code; e.pc = pc; e.ds = ds; e.bad = bad; e.npc = npc;
    sb_q.push_back(e);
  endtask

  task automatic clear_inputs();
    int_ext_i = 6'd0; timer_int_i = 1'b0; valid_i = 1'b0; stall_i = 1'b0;
    pc_i = 32'h0; is_in_delayslot_i = 1'b0; mem_addr_i = 32'h0;
    adel_if_i = 1'b0; ri_i = 1'b0; syscall_i = 1'b0; break_i = 1'b0; trap_i = 1'b0;
    ov_i = 1'b0; adel_i = 1'b0; ades_i = 1'b0; eret_i = 1'b0;
    cp0_status_i = 32'h0; cp0_cause_i = 32'h0; cp0_epc_i = 32'h0;
    wb_cp0_we_i = 1'b0; wb_cp0_waddr_i = 5'd0; wb_cp0_data_i = 32'h0;
  endtask

  // Present the current inputs for exactly one rising edge, then clear them
  task automatic fire();
    @(posedge clk); #1;
    clear_inputs();
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (flush_o === 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) check_val("flush_timeout", 32'(flush_o), 32'h0);
    @(posedge clk); #1;
  endtask

  // Monitor: pop and compare on every pulse, track flush window length and redirect
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b1) begin
      if (excepttype_o !== 32'h0) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_pulse", excepttype_o, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check_val("code", excepttype_o, e.code);
          check_val("inst_addr", current_inst_addr_o, e.pc);
          check_val("delayslot", 32'(is_in_delayslot_o), 32'(e.ds));
          check_val("bad_addr", bad_addr_o, e.bad);
          check_val("new_pc", new_pc_o, e.npc);
          check_val("flush_at_pulse", 32'(flush_o), 32'h1);
          last_npc = e.npc;
        end
        check_val("pulse_single", prev_exc, 32'h0);
      end
      if (flush_o === 1'b1) begin
        flush_len++;
        check_val("flush_npc_held", new_pc_o, last_npc);
      end else if (flush_len != 0) begin
        check_val("flush_len", 32'(flush_len), 32'(FLUSH_N));
        flush_len = 0;
      end
      prev_exc = excepttype_o;
    end else begin
      flush_len = 0;
      prev_exc  = 32'h0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_exc", excepttype_o, 32'h0);
    check_val("rst_flush", 32'(flush_o), 32'h0);
    check_val("rst_newpc", new_pc_o, 32'h0);
    check_val("rst_int", 32'(int_o), 32'h0);
    check_val("rst_bad", bad_addr_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // External interrupt: two-edge synchroniser latency, then taken on a valid instruction
    @(posedge clk); #1;
    int_ext_i = 6'b000100; cp0_status_i = 32'h0000_1001;
    @(negedge clk); check_val("int_lat0", 32'(int_o), 32'h0);
    @(negedge clk); check_val("int_lat1", 32'(int_o), 32'h0);
    @(negedge clk); check_val("int_lat2", 32'(int_o), 32'h4);
    valid_i = 1'b1; pc_i = 32'h80;
    push_exp(32'h1, 32'h80, 1'b0, exp_bad, HANDLER);
    fire(); wait_idle();

    // ri and ov together in a delay slot: ri wins
    valid_i = 1'b1; pc_i = 32'h104; is_in_delayslot_i = 1'b1; ri_i = 1'b1; ov_i = 1'b1;
    push_exp(32'ha, 32'h104, 1'b1, exp_bad, HANDLER);
    fire(); wait_idle();

    // ades held off by a three-cycle stall
    valid_i = 1'b1; pc_i = 32'h400; ades_i = 1'b1; mem_addr_i = 32'h1003; stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_val("stall_quiet", excepttype_o, 32'h0);
      check_val("stall_noflush", 32'(flush_o), 32'h0);
    end
    stall_i = 1'b0;
    exp_bad = 32'h1003;
    push_exp(32'h5, 32'h400, 1'b0, exp_bad, HANDLER);
    fire(); wait_idle();

    // eret with EPC forwarded from an mtc0 in WB
    valid_i = 1'b1; pc_i = 32'h500; eret_i = 1'b1; cp0_epc_i = 32'h200;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd14; wb_cp0_data_i = 32'h300;
    push_exp(32'he, 32'h500, 1'b0, exp_bad, 32'h300);
    fire(); wait_idle();

    // syscall, then a break in the flush window (ignored), then a break after it
    valid_i = 1'b1; pc_i = 32'h600; syscall_i = 1'b1;
    push_exp(32'h8, 32'h600, 1'b0, exp_bad, HANDLER);
    fire();
    valid_i = 1'b1; pc_i = 32'h604; break_i = 1'b1;
    fire(); wait_idle();
    valid_i = 1'b1; pc_i = 32'h608; break_i = 1'b1;
    push_exp(32'h9, 32'h608, 1'b0, exp_bad, HANDLER);
    fire(); wait_idle();

    // adel_if outranks syscall and adel; bad address is the PC
    valid_i = 1'b1; pc_i = 32'hA00; adel_if_i = 1'b1; syscall_i = 1'b1; adel_i = 1'b1;
    mem_addr_i = 32'h3000;
    exp_bad = 32'hA00;
    push_exp(32'h4, 32'hA00, 1'b0, exp_bad, HANDLER);
    fire(); wait_idle();

    // Timer interrupt beats eret
    valid_i = 1'b1; pc_i = 32'hC00; timer_int_i = 1'b1; cp0_status_i = 32'h0000_8001;
    eret_i = 1'b1; cp0_epc_i = 32'h1234;
    push_exp(32'h1, 32'hC00, 1'b0, exp_bad, HANDLER);
    fire(); wait_idle();

    // Software interrupt via cause IP forwarded from WB
    valid_i = 1'b1; pc_i = 32'hC40; cp0_status_i = 32'h0000_0201;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd13; wb_cp0_data_i = 32'h0000_0200;
    push_exp(32'h1, 32'hC40, 1'b0, exp_bad, HANDLER);
    fire(); wait_idle();

    // mtc0 clearing IE in the same cycle as a pending interrupt: nothing taken
    valid_i = 1'b1; pc_i = 32'h900; timer_int_i = 1'b1; cp0_status_i = 32'h0000_8001;
    wb_cp0_we_i = 1'b1; wb_cp0_waddr_i = 5'd12; wb_cp0_data_i = 32'h0000_8000;
    fire();
    @(negedge clk);
    check_val("ie_cleared_exc", excepttype_o, 32'h0);
    check_val("ie_cleared_flush", 32'(flush_o), 32'h0);

    // Async reset in the middle of a flush window
    @(posedge clk); #1;
    valid_i = 1'b1; pc_i = 32'h700; syscall_i = 1'b1;
    fire();
    check_val("pre_rst_flush", 32'(flush_o), 32'h1);
    #2 rst = 1'b0;
    #1;
    check_val("arst_flush", 32'(flush_o), 32'h0);
    check_val("arst_exc", excepttype_o, 32'h0);
    check_val("arst_newpc", new_pc_o, 32'h0);
    check_val("arst_addr", current_inst_addr_o, 32'h0);
    check_val("arst_bad", bad_addr_o, 32'h0);
    exp_bad = 32'h0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;

    // Normal operation resumes after reset
    @(posedge clk); #1;
    valid_i = 1'b1; pc_i = 32'hB00; adel_i = 1'b1; mem_addr_i = 32'h2001;
    exp_bad = 32'h2001;
    push_exp(32'h4, 32'hB00, 1'b0, exp_bad, HANDLER);
    fire(); wait_idle();

    repeat (4) @(posedge clk);
    check_val("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exc_ctrl.md
Name: exc_ctrl

Overview:
- Sits in the MEM stage, directly upstream of cp0.
- Synchronises external interrupt lines and decides whether the committing instruction takes an exception, interrupt or ERET.
- Drives cp0's excepttype/current_inst_addr/is_in_delayslot/bad_addr/int inputs as registered one-cycle pulses.
- Issues the pipeline flush and redirect PC, blocking new exception commits during a fixed flush window.

Parameters:
- HANDLER_ADDR, 32'hBFC00380: redirect PC for every exception except ERET.
- FLUSH_CYCLES, 2: cycles flush_o stays high per event. Legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset (low = reset).
- int_ext_i  in  6  asynchronous hardware interrupt lines.
- timer_int_i  in  1  cp0 timer interrupt, ORed into line 5.
- valid_i  in  1  MEM stage holds a real instruction.
- stall_i  in  1  MEM stage stalled this cycle.
- pc_i  in  32  PC of MEM instruction.
- is_in_delayslot_i  in  1  MEM instruction is in a delay slot.
- adel_if_i, ri_i, syscall_i, break_i, trap_i, ov_i, adel_i, ades_i, eret_i  in  1 each  exception flags.
- mem_addr_i  in  32  data address of the MEM load/store.
- cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  current cp0 registers.
- wb_cp0_we_i  in  1  mtc0 in WB.
- wb_cp0_waddr_i  in  5  mtc0 target register.
- wb_cp0_data_i  in  32  mtc0 data.
- excepttype_o  out  32  to cp0 excepttype_i.
- current_inst_addr_o  out  32  to cp0.
- is_in_delayslot_o  out  1  to cp0.
- bad_addr_o  out  32  to cp0.
- int_o  out  6  synchronised interrupts to cp0 int_i.
- flush_o  out  1  flush IF..MEM.
- new_pc_o  out  32  redirect target, valid while flush_o.

Behaviour:
- Reset (rst low, async): all outputs 0; synchroniser flops 0; FSM IDLE; counter 0.
- Interrupt sync:
  - Two-flop synchroniser per int_ext_i bit.
  - int_o = sync2 with bit5 ORed with timer_int_i. timer_int_i is not synchronised.
  - Latency from int_ext_i to int_o: 2 edges.
- WB forwarding:
  - eff_status = wb_data if wb_we and waddr==12, else cp0_status_i.
  - eff_cause[9:8] = wb_data[9:8] if wb_we and waddr==13, else cp0_cause_i[9:8].
  - eff_epc = wb_data if wb_we and waddr==14, else cp0_epc_i.
- Interrupt pending:
  - Condition: ( (int_o & eff_status[15:10]) != 0 or (eff_cause[9:8] & eff_status[9:8]) != 0 ) and eff_status[0]==1 and eff_status[1]==0.
- Cause selection, fixed priority, with code and bad_addr:
  - interrupt: 0x1.
  - adel_if: 0x4, bad_addr = pc_i.
  - ri: 0xa.
  - syscall: 0x8.
  - break: 0x9.
  - trap: 0xd.
  - ov: 0xc.
  - adel: 0x4, bad_addr = mem_addr_i.
  - ades: 0x5, bad_addr = mem_addr_i.
  - eret: 0xe.
  - none: 0.
- Commit condition: state==IDLE and valid_i and !stall_i and code!=0.
  - Stalled or invalid instructions never commit; a pending interrupt waits for the next valid unstalled instruction.
- FSM IDLE:
  - On commit, register for exactly one cycle: excepttype_o = code, current_inst_addr_o = pc_i, is_in_delayslot_o, bad_addr_o (previous value kept if not an address error).
  - Same edge: flush_o = 1; new_pc_o = eff_epc for eret, else HANDLER_ADDR; counter = FLUSH_CYCLES-1.
  - Go to FLUSH if FLUSH_CYCLES>1, else stay IDLE with flush_o cleared next cycle.
- FSM FLUSH:
  - excepttype_o = 0; flush_o held at 1; new_pc_o held; counter decrements each cycle.
  - When counter==0 at an edge: flush_o = 0, go to IDLE.
  - All flags and interrupts are ignored in FLUSH, since those instructions are being flushed.
- excepttype_o is never nonzero for two consecutive cycles.
- Simultaneous events:
  - Several flags: only the highest priority is reported.
  - Interrupt plus eret: interrupt wins.
  - mtc0 clearing IE in WB in the same cycle as a pending interrupt: no interrupt taken.
- Async reset in FLUSH: immediate return to IDLE with flush_o = 0 and no pulse.

Test Plan:
- int_ext_i[2]=1; status=0x0000_1001 (IM2=1, IE=1, EXL=0); valid instruction at pc 0x80 -> int_o[2] rises after 2 edges. Next commit gives excepttype_o=0x1 for 1 cycle, current_inst_addr_o=0x80, flush_o high 2 cycles, new_pc_o=0xBFC00380.
- ri_i and ov_i together, delayslot=1, pc=0x104 -> excepttype_o=0xa, is_in_delayslot_o=1, current_inst_addr_o=0x104.
- ades_i with mem_addr_i=0x1003 while stall_i=1 for 3 cycles -> no output until stall drops. Then excepttype_o=0x5, bad_addr_o=0x1003.
- eret_i, cp0_epc_i=0x200, WB mtc0 to EPC with data 0x300 -> excepttype_o=0xe, new_pc_o=0x300.
- syscall commit, then break_i on the very next cycle -> break ignored (in FLUSH). A break presented after flush_o falls gives excepttype_o=0x9.
- rst pulled low while flush_o=1 -> flush_o and all outputs 0 immediately, without waiting for a clock edge.
